// File: rtl/io_trap_sequencer.sv
// Z80 I/O bus watcher: control/ISR port strobes plus the trapped-port NMI sequencer.
// Optional handler watchdog and trap_overrun port are enabled by defining TRAP_TIMEOUT_EN.
module io_trap_sequencer #(
  parameter logic [7:0]  CTRL_PORT  = 8'h3F,
  parameter logic [7:0]  TRAP_BASE  = 8'hA0,
  parameter logic [7:0]  TRAP_MASK  = 8'hF0,
  parameter logic [7:0]  NMI_CYCLES = 8'd8
`ifdef TRAP_TIMEOUT_EN
  , parameter logic [15:0] TIMEOUT  = 16'hFFFF
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] addr,
  input  logic       iorq_n,
  input  logic       m1_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] ctrl_in,
  output logic       write_ctrl_en,
  output logic       read_isr_en,
  output logic       record_isr_en,
  output logic       nmi_n,
  output logic       trap_active,
  output logic [7:0] trap_port,
  output logic       trap_wr
`ifdef TRAP_TIMEOUT_EN
  , output logic     trap_overrun
`endif
);

  typedef enum logic [1:0] {IDLE, ARMED, TRAPPED, HANDLER} state_t;

  state_t     state;
  logic       iorq_q, rd_q, ctrl_cyc, trap_cyc;
  logic [7:0] nmi_cnt;
`ifdef TRAP_TIMEOUT_EN
  logic [15:0] wdog;
`endif

  logic io_start, ctrl_hit, win_hit, en, rd_rise;
  logic unused_ctrl;

  assign io_start = !iorq_n && iorq_q && m1_n;
  assign ctrl_hit = (addr == CTRL_PORT);
  // The control port is carved out of the trap window so the handler can always reach it.
  assign win_hit  = ((addr & TRAP_MASK) == TRAP_BASE) && !ctrl_hit;
  assign en       = ctrl_in[0];
  assign rd_rise  = rd_n && !rd_q;
  assign unused_ctrl = ^ctrl_in[7:1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      iorq_q        <= 1'b1;
      rd_q          <= 1'b1;
      ctrl_cyc      <= 1'b0;
      trap_cyc      <= 1'b0;
      nmi_cnt       <= 8'd0;
      write_ctrl_en <= 1'b0;
      read_isr_en   <= 1'b0;
      record_isr_en <= 1'b1;
      nmi_n         <= 1'b1;
      trap_active   <= 1'b0;
      trap_port     <= 8'h00;
      trap_wr       <= 1'b0;
`ifdef TRAP_TIMEOUT_EN
      wdog          <= 16'd0;
      trap_overrun  <= 1'b0;
`endif
    end else begin
      iorq_q <= iorq_n;
      rd_q   <= rd_n;

      // Strobes stay up until one clock after IORQ release so they straddle the WR/RD rising edge.
      if (io_start) begin
        ctrl_cyc      <= ctrl_hit;
        write_ctrl_en <= ctrl_hit && !wr_n;
        read_isr_en   <= ctrl_hit && wr_n;
      end else if (iorq_q) begin
        ctrl_cyc      <= 1'b0;
        write_ctrl_en <= 1'b0;
        read_isr_en   <= 1'b0;
      end else if (ctrl_cyc && !iorq_n) begin
        write_ctrl_en <= !wr_n;
        read_isr_en   <= wr_n;
      end

      if (trap_cyc) begin
        if (!iorq_n) trap_wr  <= !wr_n;
        else         trap_cyc <= 1'b0;
      end

`ifdef TRAP_TIMEOUT_EN
      if (write_ctrl_en) trap_overrun <= 1'b0;
`endif

      case (state)
        IDLE: if (en) state <= ARMED;
        ARMED: begin
          if (!en) state <= IDLE;
          else if (io_start && win_hit) begin
            state         <= TRAPPED;
            trap_port     <= addr;
            trap_wr       <= !wr_n;
            trap_cyc      <= 1'b1;
            nmi_cnt       <= NMI_CYCLES;
            nmi_n         <= 1'b0;
            record_isr_en <= 1'b0;
            trap_active   <= 1'b1;
          end
        end
        TRAPPED: begin
          if (!en) begin
            state         <= IDLE;
            nmi_n         <= 1'b1;
            record_isr_en <= 1'b1;
            trap_active   <= 1'b0;
          end else begin
            nmi_cnt <= nmi_cnt - 8'd1;
            if (nmi_cnt <= 8'd1) begin
              state <= HANDLER;
              nmi_n <= 1'b1;
`ifdef TRAP_TIMEOUT_EN
              wdog  <= TIMEOUT;
`endif
            end
          end
        end
        HANDLER: begin
          if (!en) begin
            state         <= IDLE;
            record_isr_en <= 1'b1;
            trap_active   <= 1'b0;
          end else if (read_isr_en && rd_rise) begin
            state         <= ARMED;
            record_isr_en <= 1'b1;
            trap_active   <= 1'b0;
          end
`ifdef TRAP_TIMEOUT_EN
          else if (wdog <= 16'd1) begin
            state         <= ARMED;
            record_isr_en <= 1'b1;
            trap_active   <= 1'b0;
            trap_overrun  <= 1'b1;
          end else begin
            wdog <= wdog - 16'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
